spi_arbiter: RTL and testbench
==============================

SPI_ARBITER -- requirements
Module: spi_arbiter

Interface
REQ-001 Parameter DATA_W, 24, SPI word width in bits.
REQ-002 Parameter BUSY_TO, 16, max cycles from spi_start until spi_ready falls.
REQ-003 Parameter DONE_TO, 4096, max cycles from spi_ready falling until it rises again.
REQ-004 clk  in  1  single system clock; all logic on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 req_valid  in  2  per-requester write request (bit0 = init/debug path, bit1 = listener path).
REQ-007 req_ready  out  2  per-requester accept; transfer occurs when valid&ready are both high.
REQ-008 req_chan  in  2  per-requester target: 0 = ADF4002 master, 1 = LMX2594 master.
REQ-009 req_data  in  2*DATA_W  per-requester word; requester n uses bits [n*DATA_W +: DATA_W].
REQ-010 req_done  out  2  one-cycle pulse to the owning requester on successful completion.
REQ-011 req_err  out  2  one-cycle pulse to the owning requester on timeout.
REQ-012 spi_ready  in  2  per-master idle flag.
REQ-013 spi_start  out  2  per-master start strobe.
REQ-014 spi_dir  out  1  constant 0 (write).
REQ-015 spi_data_tx  out  DATA_W  word driven to both masters.
REQ-016 spi_data_depth  out  8  constant DATA_W.

Function
REQ-017 FSM states SHALL be IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE; at most one transaction in flight.
REQ-018 IDLE: req_ready SHALL be high only for the granted requester, combinationally, only while in IDLE.
REQ-019 Grant: one requester valid -> that requester; both valid -> the requester not served last (round-robin pointer, reset value 1 so requester 0 wins first).
REQ-020 On accept: latch data, channel, owner; update round-robin pointer; go to LAUNCH next cycle.
REQ-021 LAUNCH: wait while spi_ready[chan]=0 (no timeout); when 1, drive spi_start[chan]=1 for exactly one cycle, go to WAIT_BUSY.
REQ-022 spi_data_tx SHALL hold the latched word from LAUNCH entry until return to IDLE.
REQ-023 WAIT_BUSY: spi_ready[chan]=0 -> WAIT_DONE; counter reaching BUSY_TO -> pulse req_err[owner], go IDLE.
REQ-024 WAIT_DONE: spi_ready[chan]=1 -> pulse req_done[owner], go IDLE; counter reaching DONE_TO -> pulse req_err[owner], go IDLE.
REQ-025 Timeout counter SHALL clear on every state entry; width SHALL be clog2(max(BUSY_TO,DONE_TO))+1, no wrap.
REQ-026 req_done and req_err SHALL never be high together, and never for the non-owner.
REQ-027 spi_start bit of the unselected channel SHALL remain 0 at all times.
REQ-028 Minimum request-to-done latency: accept cycle + 1 (LAUNCH) + 1 (WAIT_BUSY) + SPI transfer + 1.
REQ-029 A requester deasserting req_valid before accept SHALL lose its grant; no partial transaction.
REQ-030 Back-to-back: done cycle returns to IDLE; the next accept is possible on the following cycle.

Reset
REQ-031 rst_n low SHALL immediately force IDLE, spi_start=0, req_done=0, req_err=0, spi_data_tx=0, counter=0, pointer=1.
REQ-032 Reset mid-transaction SHALL abandon it without done/err pulses; spi_dir and spi_data_depth are constants.

Structure
REQ-033 Shared package holds state encoding, channel indices (CH_ADF4002=0, CH_LMX2594=1), and DATA_W default.
REQ-034 Single module; round-robin grant logic MAY be split into sub-module rr_arb2.

Verification
REQ-035 Single request: req0, chan 0, data 24'h1F8093; model drops ready 2 cycles after start and raises it 30 cycles later -> one spi_start[0] pulse, spi_data_tx=24'h1F8093 throughout, req_done[0] pulse.
REQ-036 Contention: both valid in the same cycle, chan 1 each, data 24'h700000/24'h000001 -> requester 0 served first, then 1; spi_start[1] pulses twice, in that order.
REQ-037 Busy timeout: spi_ready[0] stays 1 after start -> req_err[0] exactly BUSY_TO cycles after WAIT_BUSY entry, no req_done.
REQ-038 Done timeout: spi_ready[1] falls, never rises -> req_err pulse after DONE_TO cycles, FSM back in IDLE.
REQ-039 Reset mid-WAIT_DONE: rst_n low for 1 cycle -> all outputs 0 that cycle; no done/err pulse afterwards; next request starts cleanly.
REQ-040 Launch stall: spi_ready[0]=0 for 50 cycles at request -> no start until ready=1, then exactly one pulse.

Source files
------------

// File: rtl/spi_arbiter_pkg.sv
// Shared definitions for the two-requester SPI write arbiter: FSM encoding,
// master channel indices, default widths/timeouts and small helpers.
package spi_arbiter_pkg;

    localparam int DATA_W_DEF  = 24;
    localparam int BUSY_TO_DEF = 16;
    localparam int DONE_TO_DEF = 4096;

    localparam int NUM_REQ = 2;
    localparam int NUM_CH  = 2;

    localparam logic CH_ADF4002 = 1'b0;
    localparam logic CH_LMX2594 = 1'b1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } arb_state_e;

    // Counter must be able to hold the larger timeout value without wrapping.
    function automatic int cnt_width(input int busy_to, input int done_to);
        return $clog2((busy_to > done_to) ? busy_to : done_to) + 1;
    endfunction

    function automatic logic [NUM_REQ-1:0] sel_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/spi_arbiter_if.sv
// Requester-side handshake and SPI-master-side strobe bundle for spi_arbiter.
// The arbiter uses the slave modport; the environment uses the master modport.
interface spi_arbiter_if
    import spi_arbiter_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        req_chan;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_done;
    logic [NUM_REQ-1:0]        req_err;

    logic [NUM_CH-1:0]         spi_ready;
    logic [NUM_CH-1:0]         spi_start;
    logic                      spi_dir;
    logic [DATA_W-1:0]         spi_data_tx;
    logic [7:0]                spi_data_depth;

    modport slave (
        input  req_valid, req_chan, req_data, spi_ready,
        output req_ready, req_done, req_err,
        output spi_start, spi_dir, spi_data_tx, spi_data_depth
    );

    modport master (
        output req_valid, req_chan, req_data, spi_ready,
        input  req_ready, req_done, req_err,
        input  spi_start, spi_dir, spi_data_tx, spi_data_depth
    );

endinterface

// File: rtl/spi_arbiter_rr_arb2.sv
// Two-way round-robin grant: a lone requester always wins, on contention the
// requester not served last wins. Pointer resets to 1 so requester 0 goes first.
module spi_arbiter_rr_arb2
    import spi_arbiter_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               accept_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic               grant_idx_o
);

    logic last_q;
    logic last_d;

    always_comb begin
        grant_idx_o = 1'b0;
        unique case (req_i)
            2'b01:   grant_idx_o = 1'b0;
            2'b10:   grant_idx_o = 1'b1;
            2'b11:   grant_idx_o = ~last_q;
            default: grant_idx_o = 1'b0;
        endcase
        grant_o = req_i & sel_onehot(grant_idx_o);
        last_d  = accept_i ? grant_idx_o : last_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/spi_arbiter.sv
// Shares two SPI write masters (ADF4002, LMX2594) between two requesters,
// one transaction in flight, with busy/done timeouts reported per owner.
module spi_arbiter
    import spi_arbiter_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int BUSY_TO = BUSY_TO_DEF,
    parameter int DONE_TO = DONE_TO_DEF
)(
    input  logic          clk,
    input  logic          rst_n,
    spi_arbiter_if.slave  bus
);

    localparam int CNT_W = cnt_width(BUSY_TO, DONE_TO);
    localparam logic [CNT_W-1:0] BUSY_LIM = CNT_W'(BUSY_TO);
    localparam logic [CNT_W-1:0] DONE_LIM = CNT_W'(DONE_TO);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    arb_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              chan_q, chan_d;
    logic              owner_q, owner_d;

    logic [NUM_REQ-1:0] grant;
    logic               grant_idx;
    logic               accept;
    logic               ready_sel;
    logic               start_fire;
    logic               done_fire;
    logic               err_fire;

    assign accept    = (state_q == IDLE) && (|bus.req_valid);
    assign ready_sel = bus.spi_ready[chan_q];

    spi_arbiter_rr_arb2 u_rr (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_i       (bus.req_valid),
        .accept_i    (accept),
        .grant_o     (grant),
        .grant_idx_o (grant_idx)
    );

    // Done/err are Mealy outputs of the terminating cycle, so the FSM is back
    // in IDLE (and can accept again) on the very next cycle.
    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        chan_d     = chan_q;
        owner_d    = owner_q;
        start_fire = 1'b0;
        done_fire  = 1'b0;
        err_fire   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    owner_d = grant_idx;
                    chan_d  = bus.req_chan[grant_idx];
                    data_d  = grant_idx ? bus.req_data[2*DATA_W-1:DATA_W]
                                        : bus.req_data[DATA_W-1:0];
                    state_d = LAUNCH;
                end
            end
            LAUNCH: begin
                if (ready_sel) begin
                    start_fire = 1'b1;
                    state_d    = WAIT_BUSY;
                end
            end
            WAIT_BUSY: begin
                if (!ready_sel) begin
                    state_d = WAIT_DONE;
                end else if (cnt_q == BUSY_LIM) begin
                    err_fire = 1'b1;
                    state_d  = IDLE;
                end
            end
            WAIT_DONE: begin
                if (ready_sel) begin
                    done_fire = 1'b1;
                    state_d   = IDLE;
                end else if (cnt_q == DONE_LIM) begin
                    err_fire = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            chan_q  <= CH_ADF4002;
            owner_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            chan_q  <= chan_d;
            owner_q <= owner_d;
        end
    end

    assign bus.req_ready = (state_q == IDLE) ? grant : '0;
    assign bus.req_done  = done_fire ? sel_onehot(owner_q) : '0;
    assign bus.req_err   = err_fire  ? sel_onehot(owner_q) : '0;

    assign bus.spi_start[CH_ADF4002] = start_fire && (chan_q == CH_ADF4002);
    assign bus.spi_start[CH_LMX2594] = start_fire && (chan_q == CH_LMX2594);

    assign bus.spi_dir        = 1'b0;
    assign bus.spi_data_tx    = data_q;
    assign bus.spi_data_depth = 8'(DATA_W);

    a_done_err_exclusive : assert property (@(posedge clk) disable iff (!rst_n)
        !((|bus.req_done) && (|bus.req_err)));

    a_start_onehot : assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(bus.spi_start));

endmodule

// File: tb/tb_spi_arbiter.sv
// Directed self-checking bench for spi_arbiter with a behavioural model of the
// two SPI masters' ready/busy handshake.
module tb_spi_arbiter;

    localparam int DW      = 24;
    localparam int BUSY_TO = 16;
    localparam int DONE_TO = 4096;

    localparam int M_NORMAL      = 0;
    localparam int M_STUCK_READY = 1;
    localparam int M_STUCK_BUSY  = 2;
    localparam int M_FORCE_LOW   = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    spi_arbiter_if #(.DATA_W(DW)) bus ();

    spi_arbiter #(
        .DATA_W  (DW),
        .BUSY_TO (BUSY_TO),
        .DONE_TO (DONE_TO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    int mode [2];
    int startCyc [2];
    int startCount [2];
    int doneCount [2];
    int doneCyc [2];
    int errCount [2];
    int errCyc [2];
    logic [DW-1:0] startData [16];
    int startIdx;
    logic [DW-1:0] doneTx;
    int violCount = 0;

    // Master model: ready drops 2 cycles after a start, returns 30 cycles later.
    function automatic logic modelReady(input int ch);
        logic r;
        r = 1'b1;
        case (mode[ch])
            M_STUCK_READY: r = 1'b1;
            M_FORCE_LOW:   r = 1'b0;
            M_STUCK_BUSY:  r = (startCyc[ch] < 0) ? 1'b1 : !(cyc >= startCyc[ch] + 2);
            default:       r = (startCyc[ch] < 0) ? 1'b1 :
                               !(cyc >= startCyc[ch] + 2 && cyc < startCyc[ch] + 32);
        endcase
        return r;
    endfunction

    always @(posedge clk) begin
        #2;
        for (int ch = 0; ch < 2; ch++) bus.spi_ready[ch] = modelReady(ch);
    end

    // Event monitor, sampled mid-cycle when all inputs and outputs are settled.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int ch = 0; ch < 2; ch++) begin
                if (bus.spi_start[ch]) begin
                    startCount[ch]++;
                    startCyc[ch] = cyc;
                    if (startIdx < 16) startData[startIdx] = bus.spi_data_tx;
                    startIdx++;
                end
            end
            for (int r = 0; r < 2; r++) begin
                if (bus.req_done[r]) begin
                    doneCount[r]++;
                    doneCyc[r] = cyc;
                    doneTx = bus.spi_data_tx;
                end
                if (bus.req_err[r]) begin
                    errCount[r]++;
                    errCyc[r] = cyc;
                end
            end
            if (((|bus.req_done) && (|bus.req_err)) || ($countones(bus.spi_start) > 1) ||
                ($countones(bus.req_done) > 1) || ($countones(bus.req_err) > 1))
                violCount++;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] valid, input logic [1:0] chan,
                                 input logic [DW-1:0] d0, input logic [DW-1:0] d1);
        bus.req_valid = valid;
        bus.req_chan  = chan;
        bus.req_data  = {d1, d0};
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clearLog();
        for (int i = 0; i < 2; i++) begin
            startCyc[i] = -1;
            startCount[i] = 0;
            doneCount[i] = 0;
            doneCyc[i] = 0;
            errCount[i] = 0;
            errCyc[i] = 0;
        end
        startIdx = 0;
        doneTx = '0;
    endtask

    task automatic waitDone(input string tag, input int r, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (doneCount[r] != 0) break;
            waitCycles(1);
        end
        checkOutput(tag, 32'(doneCount[r] != 0), 32'd1);
    endtask

    task automatic waitErr(input string tag, input int r, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (errCount[r] != 0) break;
            waitCycles(1);
        end
        checkOutput(tag, 32'(errCount[r] != 0), 32'd1);
    endtask

    task automatic waitStart(input string tag, input int ch, input int n, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (startCount[ch] >= n) break;
            waitCycles(1);
        end
        checkOutput(tag, 32'(startCount[ch] >= n), 32'd1);
    endtask

    initial begin
        int acceptCyc;
        int releaseCyc;
        int base;

        mode[0] = M_NORMAL;
        mode[1] = M_NORMAL;
        clearLog();
        applyStimulus(2'b00, 2'b00, '0, '0);

        @(negedge clk);
        checkOutput("rst req_ready", 32'(bus.req_ready), 32'h0);
        checkOutput("rst spi_start", 32'(bus.spi_start), 32'h0);
        checkOutput("rst req_done", 32'(bus.req_done), 32'h0);
        checkOutput("rst req_err", 32'(bus.req_err), 32'h0);
        checkOutput("rst spi_data_tx", 32'(bus.spi_data_tx), 32'h0);
        checkOutput("spi_dir", 32'(bus.spi_dir), 32'h0);
        checkOutput("spi_data_depth", 32'(bus.spi_data_depth), 32'd24);
        @(posedge clk); #1;
        rst_n = 1'b1;
        waitCycles(2);

        $display("[TB] single request");
        applyStimulus(2'b01, 2'b00, 24'h1F8093, '0);
        acceptCyc = cyc;
        @(negedge clk);
        checkOutput("t1 grant", 32'(bus.req_ready), 32'h1);
        @(posedge clk); #1;
        bus.req_valid = 2'b00;
        waitDone("t1 done seen", 0, 100);
        checkOutput("t1 start ch0", 32'(startCount[0]), 32'd1);
        checkOutput("t1 start ch1", 32'(startCount[1]), 32'd0);
        checkOutput("t1 accept->start", 32'(startCyc[0] - acceptCyc), 32'd1);
        checkOutput("t1 start->done", 32'(doneCyc[0] - startCyc[0]), 32'd32);
        checkOutput("t1 tx at start", 32'(startData[0]), 32'h1F8093);
        checkOutput("t1 tx at done", 32'(doneTx), 32'h1F8093);
        checkOutput("t1 no err", 32'(errCount[0] + errCount[1]), 32'd0);
        checkOutput("t1 no done req1", 32'(doneCount[1]), 32'd0);

        $display("[TB] contention");
        waitCycles(2);
        rst_n = 1'b0;
        waitCycles(1);
        rst_n = 1'b1;
        clearLog();
        applyStimulus(2'b11, 2'b11, 24'h700000, 24'h000001);
        @(negedge clk);
        checkOutput("t2 first grant", 32'(bus.req_ready), 32'h1);
        @(posedge clk); #1;
        bus.req_valid = 2'b10;
        waitStart("t2 second start", 1, 2, 200);
        bus.req_valid = 2'b00;
        waitDone("t2 done req1", 1, 100);
        checkOutput("t2 start ch1", 32'(startCount[1]), 32'd2);
        checkOutput("t2 start ch0", 32'(startCount[0]), 32'd0);
        checkOutput("t2 order first", 32'(startData[0]), 32'h700000);
        checkOutput("t2 order second", 32'(startData[1]), 32'h000001);
        checkOutput("t2 done req0", 32'(doneCount[0]), 32'd1);
        checkOutput("t2 done req1", 32'(doneCount[1]), 32'd1);
        checkOutput("t2 back-to-back", 32'(startCyc[1] - doneCyc[0]), 32'd2);

        $display("[TB] busy timeout");
        waitCycles(2);
        clearLog();
        mode[0] = M_STUCK_READY;
        applyStimulus(2'b01, 2'b00, 24'hABCDEF, '0);
        @(posedge clk); #1;
        bus.req_valid = 2'b00;
        waitErr("t3 err seen", 0, 100);
        checkOutput("t3 start->err", 32'(errCyc[0] - startCyc[0]), 32'(BUSY_TO + 1));
        checkOutput("t3 no done", 32'(doneCount[0]), 32'd0);
        checkOutput("t3 no err req1", 32'(errCount[1]), 32'd0);
        checkOutput("t3 one start", 32'(startCount[0]), 32'd1);
        mode[0] = M_NORMAL;

        $display("[TB] done timeout");
        waitCycles(2);
        clearLog();
        mode[1] = M_STUCK_BUSY;
        applyStimulus(2'b10, 2'b10, '0, 24'h123456);
        @(posedge clk); #1;
        bus.req_valid = 2'b00;
        waitErr("t4 err seen", 1, DONE_TO + 200);
        checkOutput("t4 start->err", 32'(errCyc[1] - startCyc[1]), 32'(DONE_TO + 3));
        checkOutput("t4 no done", 32'(doneCount[1]), 32'd0);
        checkOutput("t4 no err req0", 32'(errCount[0]), 32'd0);
        mode[1] = M_NORMAL;
        applyStimulus(2'b10, 2'b10, '0, 24'h654321);
        @(negedge clk);
        checkOutput("t4 idle grant", 32'(bus.req_ready), 32'h2);
        #1;
        bus.req_valid = 2'b00;
        @(negedge clk);
        checkOutput("t4 withdrawn ready", 32'(bus.req_ready), 32'h0);
        waitCycles(5);
        checkOutput("t4 withdrawn no start", 32'(startCount[1]), 32'd1);

        $display("[TB] reset mid transaction");
        clearLog();
        applyStimulus(2'b01, 2'b00, 24'h0F0F0F, '0);
        @(posedge clk); #1;
        bus.req_valid = 2'b00;
        waitStart("t5 start seen", 0, 1, 20);
        waitCycles(10);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("t5 rst spi_start", 32'(bus.spi_start), 32'h0);
        checkOutput("t5 rst req_done", 32'(bus.req_done), 32'h0);
        checkOutput("t5 rst req_err", 32'(bus.req_err), 32'h0);
        checkOutput("t5 rst spi_data_tx", 32'(bus.spi_data_tx), 32'h0);
        checkOutput("t5 rst req_ready", 32'(bus.req_ready), 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        waitCycles(40);
        checkOutput("t5 no done after rst", 32'(doneCount[0]), 32'd0);
        checkOutput("t5 no err after rst", 32'(errCount[0]), 32'd0);
        base = startIdx;
        applyStimulus(2'b10, 2'b10, '0, 24'h5A5A5A);
        @(posedge clk); #1;
        bus.req_valid = 2'b00;
        waitDone("t5 clean done", 1, 100);
        checkOutput("t5 clean start", 32'(startCount[1]), 32'd1);
        checkOutput("t5 clean data", 32'(startData[base]), 32'h5A5A5A);
        checkOutput("t5 clean no err", 32'(errCount[0] + errCount[1]), 32'd0);

        $display("[TB] launch stall");
        waitCycles(2);
        clearLog();
        mode[0] = M_FORCE_LOW;
        applyStimulus(2'b01, 2'b00, 24'h33CC33, '0);
        @(posedge clk); #1;
        bus.req_valid = 2'b00;
        waitCycles(50);
        checkOutput("t6 stalled", 32'(startCount[0]), 32'd0);
        mode[0] = M_NORMAL;
        releaseCyc = cyc;
        waitDone("t6 done seen", 0, 100);
        checkOutput("t6 one start", 32'(startCount[0]), 32'd1);
        checkOutput("t6 start at release", 32'(startCyc[0] - releaseCyc), 32'd0);
        checkOutput("t6 data", 32'(startData[0]), 32'h33CC33);

        checkOutput("protocol violations", 32'(violCount), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
